// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register-write path: FSM encoding,
// queued-entry layout and the PSG register numbers used by callers.
// No logic; imported by psg_wr_fifo, psg_bus_writer and the bench.
package psg_pkg;

  // Bus-cycle FSM: one queued write walks IDLE -> ADDR -> GAP -> DATA -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_GAP  = 2'd2,
    ST_DATA = 2'd3
  } psg_state_e;

  // One queued register write: address in the upper nibble, data below it.
  localparam int ENTRY_W = 12;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } psg_wr_t;

  // Commonly used PSG register numbers.
  localparam logic [3:0] REG_A_FINE   = 4'd0;
  localparam logic [3:0] REG_A_COARSE = 4'd1;
  localparam logic [3:0] REG_MIXER    = 4'd7;
  localparam logic [3:0] REG_A_VOL    = 4'd8;

  function automatic psg_wr_t make_wr(input logic [3:0] addr, input logic [7:0] data);
    psg_wr_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/psg_wr_fifo.sv
// Request queue for PSG register writes (DEPTH entries, show-ahead read).
// Latency: an entry pushed on edge E is visible on pop_dat_o after edge E.
// Backpressure: full_o blocks pushes, even when a pop happens on the same edge.
//
// Ports:
//   clk_i       clock, all state on its rising edge
//   rst_i       synchronous active-high reset (pointers and occupancy to 0)
//   push_i      push request; ignored while full_o or rst_i is high
//   push_dat_i  entry to append
//   pop_i       pop request; ignored while empty_o
//   pop_dat_o   head entry (valid while !empty_o)
//   full_o      DEPTH entries held
//   empty_o     no entries held
module psg_wr_fifo
  import psg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_acc;
  logic             pop_acc;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push_acc  = push_i & ~full_o;
  assign pop_acc   = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_acc, pop_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_acc) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/psg_bus_writer.sv
// Queues PSG register writes and plays each out as an address latch, a gap, then a data write.
// Latency: a request accepted on edge E reaches the bus (address phase) after edge E+1 at the earliest.
// Backpressure: wr_ready = queue not full; the bus side never stalls.
//
// Ports:
//   clk_3_58MHz  PSG clock, only clock of the block
//   I_reset      synchronous active-high reset; abandons any write in flight
//   wr_valid     write request present
//   wr_ready     queue can accept a request
//   wr_addr      PSG register address
//   wr_data      PSG register data
//   BDIR, BC     PSG bus strobes (1/1 address latch, 1/0 data write, 0/0 inactive)
//   DI           PSG data/address bus
//   busy         queue non-empty or a bus write in progress
module psg_bus_writer
  import psg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 100
) (
  input  logic       clk_3_58MHz,
  input  logic       I_reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DI,
  output logic       busy
);

  localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  psg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  psg_wr_t          hold_q, hold_d;
  logic             bdir_q, bdir_d;
  logic             bc_q, bc_d;
  logic [7:0]       di_q, di_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  psg_wr_t          fifo_push_dat;
  psg_wr_t          fifo_pop_dat;

  assign fifo_push_dat = make_wr(wr_addr, wr_data);

  psg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_3_58MHz),
    .rst_i      (I_reset),
    .push_i     (wr_valid),
    .push_dat_i (fifo_push_dat),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_pop_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign busy     = (state_q != ST_IDLE) | ~fifo_empty;
  assign BDIR     = bdir_q;
  assign BC       = bc_q;
  assign DI       = di_q;

  // State register, phase counter, holding register and registered bus outputs.
  always_ff @(posedge clk_3_58MHz) begin
    if (I_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      bdir_q  <= 1'b0;
      bc_q    <= 1'b0;
      di_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      bdir_q  <= bdir_d;
      bc_q    <= bc_d;
      di_q    <= di_d;
    end
  end

  // Next state. The counter is reloaded on every state entry and the phase
  // ends on the cycle it reads zero, so a reload of HOLD_CYCLES-1 gives
  // exactly HOLD_CYCLES cycles. The pop only looks at the registered FIFO
  // occupancy, so an entry pushed this edge cannot be popped this edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ADDR;
          cnt_d    = HOLD_LAST;
        end
      end
      ST_ADDR: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_DATA;
        cnt_d   = HOLD_LAST;
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the state being entered so they change on the
  // same edge as the state. The holding register is loaded on the pop edge,
  // hence the address comes from hold_d rather than hold_q.
  always_comb begin
    hold_d = fifo_pop ? fifo_pop_dat : hold_q;
    bdir_d = 1'b0;
    bc_d   = 1'b0;
    di_d   = 8'h00;
    unique case (state_d)
      ST_ADDR: begin
        bdir_d = 1'b1;
        bc_d   = 1'b1;
        di_d   = {4'h0, hold_d.addr};
      end
      ST_GAP: begin
        di_d = hold_d.data;
      end
      ST_DATA: begin
        bdir_d = 1'b1;
        di_d   = hold_d.data;
      end
      default: begin
        bdir_d = 1'b0;
        bc_d   = 1'b0;
        di_d   = 8'h00;
      end
    endcase
  end

endmodule
